// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants, small helpers.
// Used by the receive and transmit engines; holds no logic of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        rx_idle    = 3'd0,
        rx_start   = 3'd1,
        rx_data    = 3'd2,
        rx_parity  = 3'd3,
        rx_stop    = 3'd4,
        rx_deliver = 3'd5
    } rx_state_t;

    localparam int SAMPLES_PER_BIT = 16;
    localparam int SAMP_W          = $clog2(SAMPLES_PER_BIT);

    localparam logic [SAMP_W-1:0] MID_START = SAMP_W'(7);
    localparam logic [SAMP_W-1:0] MID_BIT   = SAMP_W'(15);

    // 7-bit frames never report bit 7, whatever the shift register holds.
    function automatic logic [7:0] data_mask(input logic bit8);
        return bit8 ? 8'hFF : 8'h7F;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous idle-high inputs (rx, cts); 2 clk latency.
// No backpressure; resets to 1 so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_async.sv
// 16x oversampling UART receiver: 7/8 data bits, optional parity, stop check; byte out 1 clk after stop sample.
// No backpressure: a full holding register or full external FIFO loses the byte and sets overflow.
module uart_rx_async
    import uart_pkg::*;
#(
    parameter bit RX_FIFO = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       clear_errors,
    input  logic       fifo_full,
    output logic [7:0] rx_byte,
    output logic       receive_full,
    output logic       fifo_write_n,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    logic              rx_s;
    rx_state_t         state;
    logic [SAMP_W-1:0] samp_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              par_acc;
    logic              perr_pend;
    logic              ferr_pend;
    logic              wait_high;
    logic [2:0]        last_bit;
    logic              deliver;
    logic              lost;

    uart_rx_sync u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    assign last_bit = bit8 ? 3'd7 : 3'd6;
    assign deliver  = (state == rx_deliver);
    assign lost     = RX_FIFO ? fifo_full : (receive_full & ~read_rx_byte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= rx_idle;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_acc   <= 1'b0;
            perr_pend <= 1'b0;
            ferr_pend <= 1'b0;
            wait_high <= 1'b0;
        end else begin
            case (state)
                rx_idle: begin
                    // After a framing error on a stuck-low line, re-arm only once it idles high.
                    if (wait_high) begin
                        if (rx_s) wait_high <= 1'b0;
                    end else if (baud_clock && !rx_s) begin
                        state    <= rx_start;
                        samp_cnt <= '0;
                    end
                end
                rx_start: begin
                    if (baud_clock) begin
                        if (samp_cnt == MID_START) begin
                            if (rx_s) begin
                                state <= rx_idle;
                            end else begin
                                state     <= rx_data;
                                samp_cnt  <= '0;
                                bit_cnt   <= '0;
                                shift     <= '0;
                                par_acc   <= 1'b0;
                                perr_pend <= 1'b0;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                rx_data: begin
                    if (baud_clock) begin
                        // Counter wraps 15 -> 0 on the sampling tick, lining up the next bit centre.
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == MID_BIT) begin
                            shift[bit_cnt] <= rx_s;
                            par_acc        <= par_acc ^ rx_s;
                            if (bit_cnt == last_bit)
                                state <= parity_en ? rx_parity : rx_stop;
                            else
                                bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                rx_parity: begin
                    if (baud_clock) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == MID_BIT) begin
                            perr_pend <= (rx_s != (odd_n_even ^ par_acc));
                            state     <= rx_stop;
                        end
                    end
                end
                rx_stop: begin
                    if (baud_clock) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == MID_BIT) begin
                            ferr_pend <= ~rx_s;
                            state     <= rx_deliver;
                        end
                    end
                end
                rx_deliver: begin
                    state <= rx_idle;
                    if (ferr_pend && !rx_s) wait_high <= 1'b1;
                end
                default: state <= rx_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte      <= 8'h00;
            receive_full <= 1'b0;
            fifo_write_n <= 1'b1;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // A new error in the same clk as clear_errors keeps the flag set.
            parity_err  <= (deliver & perr_pend) | (parity_err  & ~clear_errors);
            framing_err <= (deliver & ferr_pend) | (framing_err & ~clear_errors);
            overflow    <= (deliver & lost)      | (overflow    & ~clear_errors);

            if (deliver) rx_byte <= shift & data_mask(bit8);

            if (RX_FIFO) begin
                receive_full <= 1'b0;
                fifo_write_n <= ~(deliver & ~fifo_full);
            end else begin
                fifo_write_n <= 1'b1;
                if (deliver)
                    receive_full <= 1'b1;
                else if (read_rx_byte)
                    receive_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: holding-register and FIFO-strobe instances share one serial line,
// frames are built bit by bit and checked against a frame-level model of the expected result.
module tb_uart_rx_async;

    localparam int BIT_CLK = 64;   // 16 baud ticks of 4 clk each

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic baud_clock = 1'b0;
    logic rx = 1'b1;
    logic bit8 = 1'b1;
    logic parity_en = 1'b0;
    logic odd_n_even = 1'b0;
    logic read_rx_byte = 1'b0;
    logic clear_errors = 1'b0;
    logic fifo_full = 1'b0;

    logic [7:0] rx_byte0, rx_byte1;
    logic receive_full0, receive_full1;
    logic fifo_write_n0, fifo_write_n1;
    logic parity_err0, parity_err1;
    logic framing_err0, framing_err1;
    logic overflow0, overflow1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_byte = 8'h00;
    bit m_full = 0, m_perr = 0, m_ferr = 0, m_ovf = 0;

    int wr_cnt = 0;
    logic [7:0] wr_last = 8'h00;
    int baud_div = 0;

    logic [11:0] obs0;
    assign obs0 = {rx_byte0, receive_full0, parity_err0, framing_err0, overflow0};

    uart_rx_async #(.RX_FIFO(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_errors(clear_errors), .fifo_full(fifo_full),
        .rx_byte(rx_byte0), .receive_full(receive_full0), .fifo_write_n(fifo_write_n0),
        .parity_err(parity_err0), .framing_err(framing_err0), .overflow(overflow0)
    );

    uart_rx_async #(.RX_FIFO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_errors(clear_errors), .fifo_full(fifo_full),
        .rx_byte(rx_byte1), .receive_full(receive_full1), .fifo_write_n(fifo_write_n1),
        .parity_err(parity_err1), .framing_err(framing_err1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        baud_clock = (baud_div == 0);
        baud_div = (baud_div + 1) % 4;
    end

    always @(negedge clk) begin
        if (fifo_write_n1 === 1'b0) begin
            wr_cnt = wr_cnt + 1;
            wr_last = rx_byte1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [11:0] exp0();
        return {m_byte, m_full, m_perr, m_ferr, m_ovf};
    endfunction

    function automatic bit good_par(input logic [7:0] d, input bit b8, input bit odd);
        int ones;
        ones = b8 ? $countones(d) : $countones(d & 8'h7F);
        return ((ones % 2) == 1) ^ odd;
    endfunction

    task automatic bit_out(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                              input bit pbit, input bit stop_v, input bit idle_v);
        int n;
        int ones;
        bit8 = b8;
        parity_en = pen;
        odd_n_even = odd;
        n = b8 ? 8 : 7;
        bit_out(1'b0);
        for (int i = 0; i < n; i++) bit_out(d[i]);
        if (pen) bit_out(pbit);
        bit_out(stop_v);
        ones = (b8 ? $countones(d) : $countones(d & 8'h7F)) + (pbit ? 1 : 0);
        if (m_full) m_ovf = 1;
        m_full = 1;
        m_byte = b8 ? d : {1'b0, d[6:0]};
        if (pen && ((ones % 2) != (odd ? 1 : 0))) m_perr = 1;
        if (!stop_v) m_ferr = 1;
        bit_out(idle_v);
    endtask

    task automatic pulse_read();
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
        m_full = 0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        m_perr = 0; m_ferr = 0; m_ovf = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (obs0 !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_dut0: got %h want %h", obs0, 12'h000);
        end
        vectors++;
        if ({rx_byte1, receive_full1, fifo_write_n1, parity_err1, framing_err1, overflow1}
            !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_dut1: byte=%h full=%b wr_n=%b pe=%b fe=%b ov=%b want 00/0/1/0/0/0",
                     rx_byte1, receive_full1, fifo_write_n1, parity_err1, framing_err1, overflow1);
        end
        reset_n = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_8n1();
        send_frame(8'hA5, 1, 0, 0, 0, 1, 1);
        vectors++;
        if ({rx_byte0, receive_full0, parity_err0, framing_err0} !== {8'hA5, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL 8n1_a5: byte=%h full=%b pe=%b fe=%b want a5/1/0/0",
                     rx_byte0, receive_full0, parity_err0, framing_err0);
        end
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL 8n1_model: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_7e1();
        pulse_read();
        send_frame(8'h35, 0, 1, 0, good_par(8'h35, 0, 0), 1, 1);
        vectors++;
        if (obs0 !== exp0() || parity_err0 !== 1'b0) begin
            miscompares++;
            $display("FAIL 7e1_clean: got %h want %h", obs0, exp0());
        end
        pulse_read();
        send_frame(8'h35, 0, 1, 0, !good_par(8'h35, 0, 0), 1, 1);
        vectors++;
        if ({rx_byte0, parity_err0} !== {8'h35, 1'b1}) begin
            miscompares++;
            $display("FAIL 7e1_bad_parity: byte=%h pe=%b want 35/1", rx_byte0, parity_err0);
        end
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL 7e1_model: got %h want %h", obs0, exp0());
        end
        pulse_clear();
    endtask

    task automatic test_overflow();
        pulse_read();
        pulse_clear();
        send_frame(8'h11, 1, 0, 0, 0, 1, 1);
        send_frame(8'h22, 1, 0, 0, 0, 1, 1);
        vectors++;
        if ({rx_byte0, overflow0} !== {8'h22, 1'b1} || obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL overflow_set: got %h want %h", obs0, exp0());
        end
        pulse_clear();
        vectors++;
        if ({overflow0, receive_full0} !== 2'b01 || obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL overflow_clear: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_framing();
        pulse_read();
        send_frame(8'h3C, 1, 0, 0, 0, 0, 0);
        vectors++;
        if ({rx_byte0, framing_err0} !== {8'h3C, 1'b1} || obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL framing_set: got %h want %h", obs0, exp0());
        end
        pulse_read();
        repeat (4 * BIT_CLK) @(negedge clk);
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL framing_held_low: got %h want %h", obs0, exp0());
        end
        rx = 1'b1;
        bit_out(1'b1);
        pulse_clear();
        send_frame(8'h5C, 1, 0, 0, 0, 1, 1);
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL framing_recover: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_false_start();
        int wr0;
        pulse_read();
        wr0 = wr_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL false_start_dut0: got %h want %h", obs0, exp0());
        end
        vectors++;
        if (wr_cnt !== wr0) begin
            miscompares++;
            $display("FAIL false_start_strobe: got %0d strobes want 0", wr_cnt - wr0);
        end
        send_frame(8'h96, 1, 0, 0, 0, 1, 1);
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL false_start_next_frame: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_reset_mid();
        int wr0;
        wr0 = wr_cnt;
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        m_byte = 8'h00; m_full = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
        vectors++;
        if (obs0 !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_mid_dut0: got %h want %h", obs0, 12'h000);
        end
        vectors++;
        if ({rx_byte1, fifo_write_n1, overflow1} !== {8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_dut1: byte=%h wr_n=%b ov=%b want 00/1/0",
                     rx_byte1, fifo_write_n1, overflow1);
        end
        reset_n = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        vectors++;
        if (wr_cnt !== wr0) begin
            miscompares++;
            $display("FAIL reset_mid_strobe: got %0d strobes want 0", wr_cnt - wr0);
        end
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL reset_mid_after: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_fifo();
        int wr0;
        pulse_clear();
        fifo_full = 1'b0;
        wr0 = wr_cnt;
        send_frame(8'h5A, 1, 0, 0, 0, 1, 1);
        vectors++;
        if (wr_cnt - wr0 !== 1 || wr_last !== 8'h5A) begin
            miscompares++;
            $display("FAIL fifo_write: got %0d strobes data %h want 1 strobe data 5a", wr_cnt - wr0, wr_last);
        end
        vectors++;
        if ({overflow1, receive_full1} !== 2'b00) begin
            miscompares++;
            $display("FAIL fifo_no_overflow: ov=%b full=%b want 0/0", overflow1, receive_full1);
        end
        fifo_full = 1'b1;
        send_frame(8'h5B, 1, 0, 0, 0, 1, 1);
        fifo_full = 1'b0;
        vectors++;
        if (wr_cnt - wr0 !== 1) begin
            miscompares++;
            $display("FAIL fifo_full_strobe: got %0d strobes want 1", wr_cnt - wr0);
        end
        vectors++;
        if ({rx_byte1, overflow1} !== {8'h5B, 1'b1}) begin
            miscompares++;
            $display("FAIL fifo_full_overflow: byte=%h ov=%b want 5b/1", rx_byte1, overflow1);
        end
        vectors++;
        if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL fifo_dut0_model: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit b8, pen, odd, pbit, stop_v;
        int wr0;
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            b8 = 1'($urandom_range(0, 1));
            pen = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            pbit = good_par(d, b8, odd) ^ ($urandom_range(0, 3) == 0);
            stop_v = ($urandom_range(0, 7) != 0);
            wr0 = wr_cnt;
            send_frame(d, b8, pen, odd, pbit, stop_v, 1);
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL random_frame[%0d]: got %h want %h", k, obs0, exp0());
            end
            vectors++;
            if (wr_cnt - wr0 !== 1 || wr_last !== m_byte) begin
                miscompares++;
                $display("FAIL random_fifo[%0d]: got %0d strobes data %h want 1 strobe data %h",
                         k, wr_cnt - wr0, wr_last, m_byte);
            end
            if ($urandom_range(0, 1) == 1) pulse_read();
            if ($urandom_range(0, 2) == 0) pulse_clear();
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL random_host[%0d]: got %h want %h", k, obs0, exp0());
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_overflow();
        test_framing();
        test_false_start();
        test_reset_mid();
        test_fifo();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_async.md
Name: uart_rx_async

Overview:
- Asynchronous serial receiver; the receive-side partner of the CoreUARTapb transmit engine.
- Oversamples the `rx` line at 16x the baud rate, qualifies the start bit, and shifts in 7 or 8 data bits LSB-first.
- Checks optional odd/even parity and the stop bit.
- Delivers each byte either to a holding register (RX_FIFO=0) or as a write strobe to an external receive FIFO (RX_FIFO=1).

Parameters:
- RX_FIFO, 0, 0 = single holding register with `receive_full` flag; 1 = write each byte to the external receive FIFO.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- baud_clock  input  1  one-clk-wide enable pulse at 16x the baud rate
- rx  input  1  serial input, asynchronous, idles high
- bit8  input  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  input  1  parity bit present and checked
- odd_n_even  input  1  1 = odd parity, 0 = even parity
- read_rx_byte  input  1  one-clk pulse: host consumed `rx_byte` (RX_FIFO=0)
- clear_errors  input  1  one-clk pulse: clear `parity_err`, `framing_err`, `overflow`
- fifo_full  input  1  external receive FIFO full (RX_FIFO=1)
- rx_byte  output  8  received data; bit 7 forced to 0 in 7-bit mode
- receive_full  output  1  `rx_byte` holds an unread byte (RX_FIFO=0; tied 0 when RX_FIFO=1)
- fifo_write_n  output  1  active-low, one-clk write strobe to the FIFO (RX_FIFO=1; tied 1 otherwise)
- parity_err  output  1  sticky parity error
- framing_err  output  1  sticky framing error (stop bit sampled 0)
- overflow  output  1  sticky: a byte was lost

Behaviour:
- Reset (async, reset_n=0) values:
  - `rx_byte` = 0x00; `receive_full`, `parity_err`, `framing_err`, `overflow` = 0.
  - `fifo_write_n` = 1; state = rx_idle; counters = 0; synchroniser flops = 1.
  - Reset asserted mid-frame aborts the frame with no write and no flags.
- Input path: `rx` passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s, updated on every clk.
- Counters:
  - samp_cnt, 4 bits; advances only on clk edges where `baud_clock`=1.
  - bit_cnt, 3 bits, counts data bits.
- State machine (all transitions on `baud_clock` cycles unless noted):
  - rx_idle: rx_s=0 -> rx_start, samp_cnt<=0.
  - rx_start:
    - At samp_cnt=7 (mid start bit): if rx_s=1 it was a false start -> rx_idle, no flags.
    - Otherwise -> rx_data, samp_cnt<=0, bit_cnt<=0, parity accumulator<=0.
  - rx_data:
    - At samp_cnt=15 (mid bit), shift rx_s into shift[bit_cnt] and XOR it into the accumulator.
    - Last bit is bit_cnt=7 when bit8=1, or 6 when bit8=0. After it -> rx_parity if parity_en, else rx_stop. Otherwise bit_cnt+1.
  - rx_parity: at samp_cnt=15, perr_pend <= rx_s != (odd_n_even ^ accumulator); -> rx_stop.
  - rx_stop: at samp_cnt=15, ferr_pend <= ~rx_s; -> rx_deliver.
  - rx_deliver (next clk, no baud_clock needed):
    - Commit the byte and the pending errors; -> rx_idle.
    - If ferr_pend and rx_s=0 (line held low), remain in rx_idle until rx_s=1 before re-arming.
- Delivery, RX_FIFO=0:
  - `rx_byte` <= shift; `receive_full` <= 1.
  - If `receive_full` was already 1 and `read_rx_byte` is not asserted on this clk, set `overflow` (the new byte still overwrites).
  - `read_rx_byte` in the same clk as delivery: delivery wins, `receive_full` stays 1, no overflow.
- Delivery, RX_FIFO=1:
  - `rx_byte` <= shift; `fifo_write_n`=0 for exactly one clk, unless `fifo_full`=1.
  - If `fifo_full`=1: no strobe, set `overflow`.
- `receive_full` clears on the clk after `read_rx_byte`, when no delivery occurs in that clk.
- Error flags are sticky until `clear_errors`.
  - `clear_errors` coincident with a new error: the new error wins (flag stays 1).
  - Errors set only in rx_deliver.
- parity_en=0: `parity_err` never sets.
- Latency: `rx_byte` and `receive_full`/`fifo_write_n` valid 1 clk after the stop-bit sample tick. The synchroniser adds 2 clk from the pin.
- Configuration inputs are assumed static during a frame and are sampled live; the design does not protect against changes mid-frame.

Decomposition:
- Shared package (uart_pkg) holds:
  - state encodings: rx_idle, rx_start, rx_data, rx_parity, rx_stop, rx_deliver;
  - constants SAMPLES_PER_BIT=16, MID_START=7, MID_BIT=15.
  - tx_async reuses the same package for its states.
- One natural sub-module, uart_rx_sync: the 2-flop synchroniser with reset value 1, also reused for CTS-style inputs.

Test Plan:
- 8N1, send 0xA5, baud_clock every 4 clk -> `rx_byte`=0xA5, `receive_full`=1, `parity_err`=`framing_err`=0.
- 7E1 (bit8=0, parity_en=1, odd_n_even=0), send 0x35 with correct parity 0, then with parity 1 -> first clean; second `parity_err`=1, `rx_byte`=0x35.
- RX_FIFO=0, two frames 0x11 then 0x22 with no `read_rx_byte` -> `overflow`=1, `rx_byte`=0x22. Then `clear_errors` -> `overflow`=0 while `receive_full` stays 1.
- 8N1 0x3C with stop bit driven 0 -> `framing_err`=1. No new frame starts until rx returns high.
- rx low pulse of 5 baud ticks only -> no delivery, state back in rx_idle. Separately, reset_n low mid-data -> all outputs at reset values and no `fifo_write_n` strobe.
- RX_FIFO=1, send 0x5A with fifo_full=0, then 0x5B with fifo_full=1 -> exactly one 1-clk `fifo_write_n` low carrying 0x5A, then `overflow`=1.
